// File: rtl/img_stream_loader.sv
// img_stream_loader: raster pixel stream to image SRAM write port, one write per accepted beat.
// Optional LAST_CHECK_EN adds a sticky last_err flag comparing s_last against the pixel counter.
module img_stream_loader #(
    parameter int X_MAX       = 400,
    parameter int Y_MAX       = 400,
    parameter int PIXEL_DEPTH = 8,
    localparam int XW = $clog2(X_MAX) + 1,
    localparam int YW = $clog2(Y_MAX) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [XW-1:0]          cfg_width,
    input  logic [YW-1:0]          cfg_height,
    input  logic                   s_valid,
    input  logic [PIXEL_DEPTH-1:0] s_data,
    input  logic                   s_last,
    output logic                   s_ready,
    output logic [XW-1:0]          x_addr_write,
    output logic [YW-1:0]          y_addr_write,
    output logic                   wen,
    output logic [PIXEL_DEPTH-1:0] wdat,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   cfg_err
`ifdef LAST_CHECK_EN
    ,
    output logic                   last_err
`endif
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    state_t                 state_q;
    logic [XW-1:0]          w_q, x_q, x_d, xa_q;
    logic [YW-1:0]          h_q, y_q, y_d, ya_q;
    logic [PIXEL_DEPTH-1:0] wdat_q;
    logic                   wen_q, done_q, cfg_err_q;
    logic                   beat, x_end, last_pix, cfg_ok;
    always_comb begin
        beat     = s_valid && (state_q == LOAD);
        x_end    = x_q == w_q - XW'(1);
        last_pix = x_end && (y_q == h_q - YW'(1));
        x_d      = x_end ? '0 : x_q + XW'(1);
        y_d      = x_end ? y_q + YW'(1) : y_q;
        cfg_ok   = (cfg_width != '0) && (cfg_width <= XW'(X_MAX)) &&
                   (cfg_height != '0) && (cfg_height <= YW'(Y_MAX));
    end
`ifdef LAST_CHECK_EN
    logic last_err_q;
    assign last_err = last_err_q;
`else
    logic unused_s_last;
    assign unused_s_last = s_last;
`endif
    // Counters wrap past the frame after the last beat; they are reloaded on the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            w_q       <= '0;
            h_q       <= '0;
            x_q       <= '0;
            y_q       <= '0;
            xa_q      <= '0;
            ya_q      <= '0;
            wdat_q    <= '0;
            wen_q     <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
`ifdef LAST_CHECK_EN
            last_err_q <= 1'b0;
`endif
        end else begin
            wen_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    if (cfg_ok) begin
                        w_q       <= cfg_width;
                        h_q       <= cfg_height;
                        x_q       <= '0;
                        y_q       <= '0;
                        cfg_err_q <= 1'b0;
`ifdef LAST_CHECK_EN
                        last_err_q <= 1'b0;
`endif
                        state_q   <= LOAD;
                    end else begin
                        cfg_err_q <= 1'b1;
                    end
                end
                LOAD: if (beat) begin
                    wen_q   <= 1'b1;
                    wdat_q  <= s_data;
                    xa_q    <= x_q;
                    ya_q    <= y_q;
                    x_q     <= x_d;
                    y_q     <= y_d;
                    state_q <= last_pix ? DONE : LOAD;
`ifdef LAST_CHECK_EN
                    if (s_last != last_pix) last_err_q <= 1'b1;
`endif
                end
                DONE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign s_ready      = state_q == LOAD;
    assign busy         = state_q == LOAD;
    assign x_addr_write = xa_q;
    assign y_addr_write = ya_q;
    assign wen          = wen_q;
    assign wdat         = wdat_q;
    assign frame_done   = done_q;
    assign cfg_err      = cfg_err_q;
endmodule

// File: tb/tb_img_stream_loader.sv
// tb_img_stream_loader: scoreboard bench for img_stream_loader; expected writes queued at accept, checked at wen.
module tb_img_stream_loader;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [9:0] cfg_width = '0, cfg_height = '0;
    logic       s_valid = 1'b0, s_last = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_ready, wen, busy, frame_done, cfg_err;
    logic [9:0] x_addr_write, y_addr_write;
    logic [7:0] wdat;
`ifdef LAST_CHECK_EN
    logic       last_err;
`endif

    typedef struct packed {
        int         cyc;
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] d;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0, n_bad = 0, cyc = 0, n_wr = 0, n_done = 0, exp_done_cyc = -1;
    int   mx = 0, my = 0, mw = 1, mh = 1;

    img_stream_loader dut (
        .clk(clk), .rst(rst), .start(start), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .x_addr_write(x_addr_write), .y_addr_write(y_addr_write), .wen(wen), .wdat(wdat),
        .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
`ifdef LAST_CHECK_EN
        , .last_err(last_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (wen) begin
                exp_t e, a;
                n_cmp++;
                n_wr++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL spurious_wen: x=%0d y=%0d d=%0d with empty scoreboard", x_addr_write, y_addr_write, wdat);
                end else begin
                    e = q.pop_front();
                    a = '{cyc, x_addr_write, y_addr_write, wdat};
                    if (a !== e) begin
                        n_bad++;
                        $display("FAIL write: got cyc=%0d x=%0d y=%0d d=%0d, want cyc=%0d x=%0d y=%0d d=%0d",
                                 a.cyc, a.x, a.y, a.d, e.cyc, e.x, e.y, e.d);
                    end
                end
            end
            if (frame_done) begin
                n_cmp++;
                n_done++;
                if (cyc != exp_done_cyc || wen !== 1'b0) begin
                    n_bad++;
                    $display("FAIL frame_done: cyc=%0d wen=%b, want cyc=%0d wen=0", cyc, wen, exp_done_cyc);
                end
            end
            if (s_valid && s_ready) begin
                q.push_back('{cyc + 1, 10'(mx), 10'(my), s_data});
                if (mx == mw - 1 && my == mh - 1) exp_done_cyc = cyc + 2;
                if (mx == mw - 1) begin
                    mx = 0;
                    my++;
                end else mx++;
            end
        end
    end

    task automatic start_frame(input int w, input int h);
        start = 1'b1;
        cfg_width = 10'(w);
        cfg_height = 10'(h);
        mw = w; mh = h; mx = 0; my = 0; n_wr = 0; n_done = 0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input int n, input bit toggle, input int base, input int last_beat);
        int i = 0, t = 0;
        bit acc;
        while (i < n && t < 1000) begin
            s_valid = toggle ? (t % 2 == 0) : 1'b1;
            s_data = 8'(base + i);
            s_last = (i + 1 == last_beat);
            @(negedge clk);
            acc = s_valid && s_ready;
            @(posedge clk); #1;
            if (acc) i++;
            t++;
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        n_cmp++;
        if (i != n) begin
            n_bad++;
            $display("FAIL feed_timeout: accepted %0d beats, want %0d", i, n);
        end
    endtask

    task automatic wait_done(input int want_wr);
        int t = 0;
        while (n_done == 0 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (n_done != 1 || n_wr != want_wr || q.size() != 0) begin
            n_bad++;
            $display("FAIL frame_end: done_pulses=%0d writes=%0d pending=%0d, want 1 %0d 0", n_done, n_wr, q.size(), want_wr);
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({s_ready, wen, busy, frame_done, cfg_err, x_addr_write, y_addr_write, wdat} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: outputs=%h, want 0", {s_ready, wen, busy, frame_done, cfg_err, x_addr_write, y_addr_write, wdat});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_frame();
        start_frame(4, 4);
        feed(5, 1'b0, 50, 0);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({s_ready, wen, busy, frame_done, cfg_err, x_addr_write, y_addr_write, wdat} !== '0) begin
            n_bad++;
            $display("FAIL mid_reset: outputs=%h, want 0", {s_ready, wen, busy, frame_done, cfg_err, x_addr_write, y_addr_write, wdat});
        end
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        start_frame(4, 4);
        feed(16, 1'b0, 100, 0);
        wait_done(16);
    endtask

    task automatic test_full_frame();
        start_frame(4, 4);
        n_cmp++;
        if (busy !== 1'b1 || s_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL load_entry: busy=%b s_ready=%b, want 1 1", busy, s_ready);
        end
        feed(16, 1'b0, 0, 0);
        wait_done(16);
        n_cmp++;
        if (busy !== 1'b0 || s_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL after_frame: busy=%b s_ready=%b, want 0 0", busy, s_ready);
        end
    endtask

    task automatic test_toggle();
        start_frame(3, 2);
        feed(6, 1'b1, 200, 0);
        wait_done(6);
    endtask

    task automatic test_illegal_cfg();
        int bad_w[3] = '{0, 401, 3};
        int bad_h[3] = '{2, 2, 0};
        for (int k = 0; k < 3; k++) begin
            start = 1'b1;
            cfg_width = 10'(bad_w[k]);
            cfg_height = 10'(bad_h[k]);
            @(posedge clk); #1;
            start = 1'b0;
            @(posedge clk); #1;
            n_cmp++;
            if (cfg_err !== 1'b1 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL illegal_cfg%0d: cfg_err=%b busy=%b, want 1 0", k, cfg_err, busy);
            end
        end
        start_frame(2, 2);
        n_cmp++;
        if (cfg_err !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL legal_after_err: cfg_err=%b busy=%b, want 0 1", cfg_err, busy);
        end
        feed(4, 1'b0, 30, 0);
        wait_done(4);
    endtask

    task automatic test_back_to_back();
        int t = 0;
        start_frame(2, 2);
        feed(4, 1'b0, 70, 0);
        @(negedge clk);
        while (!frame_done && t < 20) begin
            @(negedge clk);
            t++;
        end
        start = 1'b1;
        cfg_width = 10'd3;
        cfg_height = 10'd1;
        @(posedge clk); #1;
        start = 1'b0;
        n_done = 0; n_wr = 0; mw = 3; mh = 1; mx = 0; my = 0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL start_on_done: busy=%b, want 1", busy);
        end
        feed(3, 1'b0, 90, 0);
        wait_done(3);
        start_frame(1, 1);
        feed(1, 1'b0, 9, 0);
        wait_done(1);
    endtask

`ifdef LAST_CHECK_EN
    task automatic test_last_check();
        start_frame(2, 2);
        feed(4, 1'b0, 10, 2);
        wait_done(4);
        n_cmp++;
        if (last_err !== 1'b1) begin
            n_bad++;
            $display("FAIL last_early: last_err=%b, want 1", last_err);
        end
        start_frame(2, 2);
        feed(4, 1'b0, 20, 4);
        wait_done(4);
        n_cmp++;
        if (last_err !== 1'b0) begin
            n_bad++;
            $display("FAIL last_ok: last_err=%b, want 0", last_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_reset_mid_frame();
        test_full_frame();
        test_toggle();
        test_illegal_cfg();
        test_back_to_back();
`ifdef LAST_CHECK_EN
        test_last_check();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/img_stream_loader.md
Name: img_stream_loader

Overview:
- Writer end of the image SRAM interface; `orb_fast_conv` is the reader on the other end.
- Accepts a raster-order pixel stream over a valid/ready handshake.
- Generates `sram_image` write-port traffic (`x_addr_write`, `y_addr_write`, `wen`, `wdat`), one pixel per accepted beat.
- On frame completion emits a one-cycle `frame_done` pulse that drives `new_trans` of the downstream pipeline.

Parameters:
- X_MAX, 400, maximum image width in pixels.
- Y_MAX, 400, maximum image height in pixels.
- PIXEL_DEPTH, 8, bits per pixel.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; latch cfg and begin a frame.
- cfg_width  in  $clog2(X_MAX)+1  frame width in pixels.
- cfg_height  in  $clog2(Y_MAX)+1  frame height in pixels.
- s_valid  in  1  stream pixel valid.
- s_data  in  PIXEL_DEPTH  stream pixel.
- s_last  in  1  upstream end-of-frame marker; used only with LAST_CHECK_EN.
- s_ready  out  1  loader can accept a pixel.
- x_addr_write  out  $clog2(X_MAX)+1  SRAM write column.
- y_addr_write  out  $clog2(Y_MAX)+1  SRAM write row.
- wen  out  1  SRAM write enable.
- wdat  out  PIXEL_DEPTH  SRAM write data.
- busy  out  1  high while in LOAD.
- frame_done  out  1  one-cycle pulse; frame fully written.
- cfg_err  out  1  sticky; illegal cfg at start. Cleared by the next legal start or by rst.

Behaviour:
- Reset (asynchronous, rst=1): all outputs 0, state IDLE, x/y counters 0, latched cfg 0. A partial frame is discarded; SRAM contents are not touched.
- States: IDLE, LOAD, DONE.
- IDLE:
  - s_ready=0.
  - On start with 1<=cfg_width<=X_MAX and 1<=cfg_height<=Y_MAX: latch W/H, clear x=y=0, clear cfg_err, go to LOAD.
  - On start with illegal cfg: set cfg_err, stay in IDLE.
- LOAD:
  - s_ready=1 combinationally; busy=1.
  - A beat is accepted when s_valid&s_ready.
  - Accepted beat in cycle N: in cycle N+1, wen=1, wdat=s_data(N), x_addr_write/y_addr_write = counter values at N. Outputs are registered; latency is 1.
  - Counter update per beat: if x==W-1 then x=0, y=y+1; else x=x+1.
  - No beat accepted: wen=0 next cycle; address and data outputs hold their last values.
  - Beat at x==W-1 and y==H-1 is the last pixel: go to DONE, s_ready drops in the following cycle.
  - start during LOAD is ignored.
- DONE:
  - Lasts one cycle; the last wen is issued in this cycle.
  - Next cycle: frame_done=1 for exactly one cycle, state returns to IDLE.
  - Therefore frame_done first rises 2 cycles after the last beat is accepted, and is never coincident with wen.
- start in the same cycle frame_done is high is honoured.
- Back-to-back beats give one write per cycle; throughput is 1 pixel/clk.
- Total writes per frame = W*H exactly. Addresses never exceed W-1 or H-1.
- Minimum frame W=H=1: single beat goes straight to DONE.

Optional Feature:
- Macro: LAST_CHECK_EN.
- Defined:
  - Output port last_err (1 bit, sticky, cleared on legal start or rst).
  - Set when an accepted beat has s_last=1 but is not the final pixel, or the final pixel arrives with s_last=0.
  - Loading continues by counter in either case.
  - The loader never terminates early on s_last.
- Undefined: s_last is ignored and the last_err port does not exist.

Test Plan:
- Reset mid-frame: W=H=4, assert rst after 5 beats -> all outputs 0, s_ready=0; after release, a new start(4,4) writes (0,0) first.
- Full 4x4 frame with continuous s_valid, data=0..15:
  - 16 wen pulses, addresses raster (0,0)..(3,3), wdat matches.
  - frame_done rises exactly 2 cycles after the 16th accept and lasts 1 cycle.
- 3x2 frame with s_valid toggling every other cycle -> 6 writes, no duplicates or gaps, each wen exactly 1 cycle after its accept.
- Illegal cfg:
  - start with cfg_width=0 -> cfg_err=1, busy stays 0.
  - start with cfg_width=401 -> cfg_err=1, busy stays 0.
  - Subsequent start(2,2) -> cfg_err=0, 4 writes.
- Full 400x400 frame (`doggo_image.hex` pixels) feeding `sram_image`, then `dump_img` -> output identical to input; frame_done drives `orb_fast_conv` new_trans and img_done eventually asserts.
- LAST_CHECK_EN on a 2x2 frame:
  - s_last on beat 2 -> last_err=1.
  - s_last only on beat 4 -> last_err=0.
